s_box_inverse: RTL and testbench
================================

S_BOX_INVERSE -- requirements
Module: s_box_inverse

Interface
REQ-001 SHALL have parameter AFFINE_CONSTANT, default 8'h63, the forward affine constant removed before the inverse affine transform.
REQ-002 SHALL have parameter GF_INVERT, default 1; 1 = full InvSubBytes (inverse affine, then GF(2^8) inverse); 0 = inverse affine only (output is the multiplicative inverse).
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port idata, input, 8 bits, S-box output byte to be inverted.
REQ-006 SHALL have port ivalid, input, 1 bit, idata valid.
REQ-007 SHALL have port iready, output, 1 bit, block can accept idata.
REQ-008 SHALL have port odata, output, 8 bits, result byte.
REQ-009 SHALL have port ovalid, output, 1 bit, odata valid.
REQ-010 SHALL have port oready, input, 1 bit, consumer accepts odata.

Function
REQ-011 SHALL implement an FSM with states IDLE, AFFINE, INVERT, DONE.
REQ-012 IDLE: iready=1; on an edge with ivalid=1, SHALL capture idata into an input register and go to AFFINE; with ivalid=0, SHALL stay in IDLE.
REQ-013 AFFINE (1 cycle): t = in_reg XOR AFFINE_CONSTANT; y = (t rotl 1) XOR (t rotl 3) XOR (t rotl 6).
REQ-014 AFFINE, GF_INVERT=0: SHALL load result <= y and go to DONE.
REQ-015 AFFINE, GF_INVERT=1: SHALL load sq <= y, acc <= 8'h01, cnt <= 0, and go to INVERT.
REQ-016 INVERT: each cycle s2 = sq*sq, sq <= s2, acc <= acc*s2, cnt <= cnt+1; all products in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11B).
REQ-017 INVERT: on the 7th INVERT cycle (cnt==6), result <= acc*s2 (= y^254) and the FSM goes to DONE.
REQ-018 y=0 SHALL produce 0 with no special-case path, since 0^254 = 0.
REQ-019 DONE: ovalid=1, odata=result; on an edge with oready=1, SHALL go to IDLE.
REQ-020 DONE: while oready=0, SHALL hold odata and ovalid stable indefinitely.
REQ-021 iready SHALL be 1 only in IDLE and 0 in all other states; ivalid outside IDLE SHALL be ignored and no input captured.
REQ-022 Latency (GF_INVERT=1): accept at edge E0 -> ovalid high after edge E0+8.
REQ-023 Latency (GF_INVERT=0): accept at edge E0 -> ovalid high after edge E0+1.
REQ-024 Maximum throughput is one byte per 10 cycles (GF_INVERT=1) or one byte per 3 cycles (GF_INVERT=0) when oready is held at 1.
REQ-025 ovalid SHALL be 0 in every state except DONE.
REQ-026 odata SHALL retain the last result after leaving DONE until the next result is loaded.
REQ-027 Round trip: s_box_inverse applied to any forward S-box output SHALL return the original byte for all 256 values.

Reset
REQ-028 While rst=1: state=IDLE, odata=8'h00, ovalid=0, iready=0, in_reg/sq/acc/cnt/result cleared.
REQ-029 After rst deasserts: iready=1 from the first cycle.
REQ-030 rst asserted in any state (including mid-INVERT or DONE with oready=0) SHALL abort the operation immediately; the pending result SHALL never appear on odata.

Verification
REQ-031 GF_INVERT=1, idata=8'h27 accepted -> exactly 8 edges later ovalid=1, odata=8'h3D; idata=8'h63 -> 8'h00; idata=8'h00 -> 8'h52; idata=8'h16 -> 8'hFF.
REQ-032 GF_INVERT=0, idata=8'h27 -> ovalid after 1 edge, odata=8'hBB; idata=8'h63 -> 8'h00.
REQ-033 Backpressure: idata=8'hED (expect 8'h53), oready=0 for 20 cycles -> odata/ovalid stable and iready=0 throughout, ivalid pulses ignored; oready=1 -> one transfer, then IDLE.
REQ-034 Exhaustive: all 256 inputs with random ivalid/oready gaps -> outputs match the InvSubBytes table; the forward S-box feeding this block returns each original byte.
REQ-035 Reset asserted asynchronously mid-INVERT -> ovalid=0 and odata=8'h00 immediately; after release, a new byte (8'h7C) -> 8'h01 with normal latency.

Source files
------------

// File: rtl/s_box_inverse.sv
// Inverse AES S-box (InvSubBytes) with a valid/ready handshake on both sides.
// The inverse affine transform takes one cycle. The GF(2^8) inverse is
// computed as y^254 using square-and-multiply over seven cycles, so it needs
// no lookup table. y = 0 maps to 0 without a special case, because 0^254 = 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | iready high; waiting for ivalid to capture idata
// AFFINE  | strip the affine constant and apply the inverse affine mapping
// INVERT  | one squaring plus one multiply per cycle, seven cycles (cnt 0..6)
// DONE    | ovalid high; result held until oready
module s_box_inverse #(
  parameter logic [7:0] AFFINE_CONSTANT = 8'h63,
  parameter int         GF_INVERT       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_AFFINE = 2'd1;
  localparam logic [1:0] ST_INVERT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] CNT_LAST  = 3'd6;

  logic [1:0] state_q, state_d;
  logic [7:0] in_q, in_d;
  logic [7:0] sq_q, sq_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] result_q, result_d;
  logic [2:0] cnt_q, cnt_d;

  logic [7:0] aff_t;
  logic [7:0] aff_y;
  logic [7:0] sq_sq;
  logic [7:0] acc_mul;

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Datapath: inverse affine mapping and the square/multiply step
  always_comb begin
    aff_t   = in_q ^ AFFINE_CONSTANT;
    aff_y   = {aff_t[6:0], aff_t[7]} ^ {aff_t[4:0], aff_t[7:5]} ^ {aff_t[1:0], aff_t[7:2]};
    sq_sq   = gf_mul(sq_q, sq_q);
    acc_mul = gf_mul(acc_q, sq_sq);
  end

  // Next-state and register-load decisions
  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    sq_d     = sq_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (ivalid) begin
          in_d    = idata;
          state_d = ST_AFFINE;
        end
      end
      ST_AFFINE: begin
        if (GF_INVERT != 0) begin
          sq_d    = aff_y;
          acc_d   = 8'h01;
          cnt_d   = 3'd0;
          state_d = ST_INVERT;
        end else begin
          result_d = aff_y;
          state_d  = ST_DONE;
        end
      end
      ST_INVERT: begin
        sq_d  = sq_sq;
        acc_d = acc_mul;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_mul;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (oready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      in_q     <= 8'h00;
      sq_q     <= 8'h00;
      acc_q    <= 8'h00;
      cnt_q    <= 3'd0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      sq_q     <= sq_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs; iready stays low for as long as reset is asserted
  always_comb begin
    iready = (state_q == ST_IDLE) && !rst;
    ovalid = (state_q == ST_DONE);
    odata  = result_q;
  end

endmodule

// File: tb/tb_s_box_inverse.sv
// Testbench for s_box_inverse. Two instances are used: full InvSubBytes
// (GF_INVERT=1) and inverse-affine-only (GF_INVERT=0). The reference tables
// are built from first principles: a brute-force GF inverse and the forward
// affine map, each inverted by table lookup.
module tb_s_box_inverse;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] idata [2];
  logic       ivalid [2];
  logic       iready [2];
  logic [7:0] odata [2];
  logic       ovalid [2];
  logic       oready [2];

  logic       ordy_rand [2];
  logic       ordy_bit  [2];
  logic       ordy_fix  [2];

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  logic [7:0] aff_inv [256];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit rt_on = 0;
  int rt_q[$];

  int         m_busy [2];
  bit         m_done [2];
  logic [7:0] m_od   [2];
  logic [7:0] m_pend [2];

  always #5 clk = ~clk;

  assign oready[0] = ordy_rand[0] ? ordy_bit[0] : ordy_fix[0];
  assign oready[1] = ordy_rand[1] ? ordy_bit[1] : ordy_fix[1];

  s_box_inverse #(.AFFINE_CONSTANT(8'h63), .GF_INVERT(1)) u_full (
    .clk(clk), .rst(rst), .idata(idata[0]), .ivalid(ivalid[0]), .iready(iready[0]),
    .odata(odata[0]), .ovalid(ovalid[0]), .oready(oready[0]));

  s_box_inverse #(.AFFINE_CONSTANT(8'h63), .GF_INVERT(0)) u_aff (
    .clk(clk), .rst(rst), .idata(idata[1]), .ivalid(ivalid[1]), .iready(iready[1]),
    .odata(odata[1]), .ovalid(ovalid[1]), .oready(oready[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11B;
    end
    return 8'(r);
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] v);
    return v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
  endfunction

  // Timing model: an accepted byte appears after a fixed latency and is held until taken
  initial begin
    m_busy = '{0, 0};
    m_done = '{0, 0};
    m_od   = '{8'h00, 8'h00};
    m_pend = '{8'h00, 8'h00};
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_busy[d] = 0;
          m_done[d] = 0;
          m_od[d]   = 8'h00;
        end else if (m_done[d]) begin
          if (oready[d]) m_done[d] = 0;
        end else if (m_busy[d] != 0) begin
          m_busy[d] = m_busy[d] - 1;
          if (m_busy[d] == 0) begin
            m_done[d] = 1;
            m_od[d]   = m_pend[d];
          end
        end else if (ivalid[d]) begin
          m_busy[d] = (d == 0) ? 8 : 1;
          m_pend[d] = (d == 0) ? inv_tab[idata[d]] : aff_inv[idata[d]];
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model, plus round-trip scoreboard
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ovalid%0d", d), int'(ovalid[d]), int'(m_done[d]));
        chk($sformatf("iready%0d", d), int'(iready[d]),
            int'(!rst && !m_done[d] && m_busy[d] == 0));
        chk($sformatf("odata%0d", d), int'(odata[d]), int'(m_od[d]));
      end
      if (rt_on && ovalid[0] && oready[0]) begin
        if (rt_q.size() == 0) chk("round_trip_queue", rt_q.size(), 1);
        else chk("round_trip", int'(odata[0]), rt_q.pop_front());
      end
    end
  end

  // Random oready source
  initial forever begin
    @(posedge clk);
    #1;
    ordy_bit[0] = 1'($urandom_range(0, 1));
    ordy_bit[1] = 1'($urandom_range(0, 1));
  end

  task automatic send(input int d, input logic [7:0] x, input bit rnd);
    bit   ok = 0;
    logic r, v;
    idata[d] = x;
    for (int k = 0; k < 400 && !ok; k++) begin
      ivalid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      r = iready[d];
      v = ivalid[d];
      @(posedge clk);
      #1;
      if (r && v) ok = 1;
    end
    ivalid[d] = 1'b0;
    idata[d]  = 8'($urandom);
    if (!ok) chk("send_timeout", int'(ok), 1);
  endtask

  task automatic wait_ov(input int d, output int n);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (ovalid[d]) break;
    end
  endtask

  initial begin
    int n;
    ivalid    = '{1'b0, 1'b0};
    idata     = '{8'h00, 8'h00};
    ordy_rand = '{1'b0, 1'b0};
    ordy_bit  = '{1'b0, 1'b0};
    ordy_fix  = '{1'b1, 1'b1};

    for (int b = 0; b < 256; b++) begin
      logic [7:0] bb, gi;
      bb = 8'(b);
      gi = 8'h00;
      if (b != 0)
        for (int c = 1; c < 256; c++)
          if (gmul(bb, 8'(c)) == 8'h01) gi = 8'(c);
      fwd_tab[b] = fwd_affine(gi);
      inv_tab[fwd_tab[b]] = bb;
      aff_inv[fwd_affine(bb)] = bb;
    end

    chk("model_inv_27", int'(inv_tab[8'h27]), 'h3D);
    chk("model_inv_63", int'(inv_tab[8'h63]), 'h00);
    chk("model_inv_00", int'(inv_tab[8'h00]), 'h52);
    chk("model_inv_16", int'(inv_tab[8'h16]), 'hFF);
    chk("model_inv_ED", int'(inv_tab[8'hED]), 'h53);
    chk("model_inv_7C", int'(inv_tab[8'h7C]), 'h01);
    chk("model_aff_27", int'(aff_inv[8'h27]), 'hBB);
    chk("model_aff_63", int'(aff_inv[8'h63]), 'h00);
    chk("model_fwd_00", int'(fwd_tab[0]), 'h63);

    #2 rst = 1'b1;
    #1 chk_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed GF_INVERT=1 vectors with latency
    send(0, 8'h27, 0);
    wait_ov(0, n);
    chk("lat_27", n, 8);
    chk("odata_27", int'(odata[0]), 'h3D);
    send(0, 8'h63, 0); wait_ov(0, n); chk("odata_63", int'(odata[0]), 'h00);
    send(0, 8'h00, 0); wait_ov(0, n); chk("odata_00", int'(odata[0]), 'h52);
    send(0, 8'h16, 0); wait_ov(0, n); chk("odata_16", int'(odata[0]), 'hFF);
    @(posedge clk); #1;

    // Backpressure with ignored ivalid pulses
    ordy_fix[0] = 1'b0;
    send(0, 8'hED, 0);
    wait_ov(0, n);
    chk("lat_ED", n, 8);
    for (int k = 0; k < 20; k++) begin
      ivalid[0] = 1'($urandom_range(0, 1));
      idata[0]  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("bp_odata", int'(odata[0]), 'h53);
      chk("bp_ovalid", int'(ovalid[0]), 1);
      chk("bp_iready", int'(iready[0]), 0);
    end
    ivalid[0]   = 1'b0;
    ordy_fix[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ovalid", int'(ovalid[0]), 0);
    chk("bp_release_iready", int'(iready[0]), 1);
    chk("bp_retain_odata", int'(odata[0]), 'h53);

    // Exhaustive round trip with random ivalid/oready gaps
    ordy_rand[0] = 1'b1;
    rt_on = 1;
    for (int i = 0; i < 256; i++) begin
      rt_q.push_back(i);
      send(0, fwd_tab[i], 1);
    end
    for (int k = 0; k < 200 && rt_q.size() != 0; k++) @(posedge clk);
    chk("round_trip_drain", rt_q.size(), 0);
    rt_on = 0;
    ordy_rand[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-INVERT
    send(0, 8'h27, 0);
    wait_ov(0, n);
    @(posedge clk); #1;
    send(0, 8'h10, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_ovalid", int'(ovalid[0]), 0);
    chk("rst_odata", int'(odata[0]), 'h00);
    chk("rst_iready", int'(iready[0]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'h7C, 0);
    wait_ov(0, n);
    chk("lat_7C", n, 8);
    chk("odata_7C", int'(odata[0]), 'h01);

    // Inverse-affine-only instance
    send(1, 8'h27, 0);
    wait_ov(1, n);
    chk("aff_lat_27", n, 1);
    chk("aff_odata_27", int'(odata[1]), 'hBB);
    @(posedge clk); #1;
    send(1, 8'h63, 0);
    wait_ov(1, n);
    chk("aff_odata_63", int'(odata[1]), 'h00);
    ordy_rand[1] = 1'b1;
    for (int i = 0; i < 40; i++) send(1, 8'($urandom), 1);
    ordy_rand[1] = 1'b0;
    repeat (10) @(posedge clk);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
